// File: rtl/exe_stage.sv
// Execute stage of the five-stage ARM core: operand forwarding, Val2 generation,
// ALU with NZCV flags, branch target, and the architectural status register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [3:0]  EXE_CMD,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic        B,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] MEM_ALU_result,
  input  logic [31:0] WB_value,
  output logic [31:0] ALU_result,
  output logic [31:0] Val_Rm_out,
  output logic [31:0] Branch_Address,
  output logic        Branch_taken,
  output logic [3:0]  SR
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [31:0] rn_f;
  logic [31:0] rm_f;
  logic [31:0] val2;
  logic [32:0] sum;
  logic [31:0] result;
  logic        c_next;
  logic        v_next;
  logic        c_in;

  assign c_in = SR[1];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rn_f = Val_Rn;
    rm_f = Val_Rm;
    case (sel_src1)
      2'b01:   rn_f = MEM_ALU_result;
      2'b10:   rn_f = WB_value;
      default: ;
    endcase
    case (sel_src2)
      2'b01:   rm_f = MEM_ALU_result;
      2'b10:   rm_f = WB_value;
      default: ;
    endcase
  end

  // Loads/stores take the raw 12-bit offset, ahead of the immediate-rotate form.
  always_comb begin
    val2 = rm_f;
    if (MEM_R_EN || MEM_W_EN) begin
      val2 = {20'b0, Shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
    end else if (Shift_operand[11:7] != 5'd0) begin
      case (Shift_operand[6:5])
        2'b00:   val2 = rm_f << Shift_operand[11:7];
        2'b01:   val2 = rm_f >> Shift_operand[11:7];
        2'b10:   val2 = $unsigned($signed(rm_f) >>> Shift_operand[11:7]);
        default: val2 = ror32(rm_f, Shift_operand[11:7]);
      endcase
    end
  end

  // Subtraction adds the inverted operand so the carry out is NOT borrow.
  always_comb begin
    sum    = '0;
    result = '0;
    c_next = SR[1];
    v_next = SR[0];
    case (exe_cmd_e'(EXE_CMD))
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, rn_f} + {1'b0, val2}
               + ((EXE_CMD == CMD_ADC) ? {32'b0, c_in} : 33'd0);
        result = sum[31:0];
        c_next = sum[32];
        v_next = (rn_f[31] == val2[31]) && (result[31] != rn_f[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, rn_f} + {1'b0, ~val2}
               + ((EXE_CMD == CMD_SBC) ? {32'b0, c_in} : 33'd1);
        result = sum[31:0];
        c_next = sum[32];
        v_next = (rn_f[31] != val2[31]) && (result[31] != rn_f[31]);
      end
      CMD_AND: result = rn_f & val2;
      CMD_ORR: result = rn_f | val2;
      CMD_EOR: result = rn_f ^ val2;
      default: ;
    endcase
  end

  assign ALU_result     = result;
  assign Val_Rm_out     = rm_f;
  assign Branch_taken   = B;
  assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      SR <= 4'b0000;
    end else if (S && !freeze) begin
      SR <= {result[31], (result == 32'd0), c_next, v_next};
    end
  end

endmodule
